// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer between the core and a multi-cycle word-organised data memory.
// Optional DMEM_MISALIGN_SPLIT_EN: misaligned accesses become two memory beats instead of an error.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_mask,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_REQ2, S_WAIT2, S_DONE} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic              we_q, we_d, split_q, split_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_mask_q, mem_mask_d, hi_mask_q, hi_mask_d;
  logic [31:0]       hi_wdata_q, hi_wdata_d, lo_rdata_q, lo_rdata_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [3:0]  size_mask;
  logic [7:0]  lane_mask;
  logic [63:0] wdata_sh;
  logic        legal, crosses;
  logic [31:0] beat_lo, beat_hi, raw, load_ext;

  // Lanes are computed over an 8-byte window so a word-crossing access falls out as the high nibble.
  always_comb begin
    case (req_funct3[1:0])
      2'd0:    size_mask = 4'b0001;
      2'd1:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    lane_mask = {4'b0000, size_mask} << req_addr[1:0];
    wdata_sh  = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};
    crosses   = |lane_mask[7:4];
    if (req_we) legal = (req_funct3 < 3'd3);
    else        legal = (req_funct3 != 3'd3) && (req_funct3 < 3'd6);
  end

  always_comb begin
    if (state_q == S_WAIT2) begin
      beat_lo = lo_rdata_q;
      beat_hi = mem_rdata;
    end else begin
      beat_lo = mem_rdata;
      beat_hi = '0;
    end
    raw = 32'({beat_hi, beat_lo} >> {off_q, 3'b000});
    case (funct3_q)
      3'd0:    load_ext = {{24{raw[7]}}, raw[7:0]};
      3'd1:    load_ext = {{16{raw[15]}}, raw[15:0]};
      3'd4:    load_ext = {24'h0, raw[7:0]};
      3'd5:    load_ext = {16'h0, raw[15:0]};
      default: load_ext = raw;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    split_d     = split_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_mask_d  = mem_mask_q;
    hi_mask_d   = hi_mask_q;
    hi_wdata_d  = hi_wdata_q;
    lo_rdata_d  = lo_rdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    stall       = 1'b0;
    rsp_valid   = 1'b0;
    mem_req     = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall = req_valid;
        if (req_valid) begin
          we_d        = req_we;
          funct3_d    = req_funct3;
          off_d       = req_addr[1:0];
          split_d     = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          mem_we_d    = req_we;
          mem_addr_d  = {req_addr[31:2], 2'b00};
          mem_wdata_d = wdata_sh[31:0];
          mem_mask_d  = lane_mask[3:0];
          hi_wdata_d  = wdata_sh[63:32];
          hi_mask_d   = lane_mask[7:4];
          state_d     = S_REQ;
          if (!legal) begin
            state_d   = S_DONE;
            rsp_err_d = 1'b1;
          end else if (crosses) begin
`ifdef DMEM_MISALIGN_SPLIT_EN
            split_d   = 1'b1;
`else
            state_d   = S_DONE;
            rsp_err_d = 1'b1;
`endif
          end
        end
      end
      S_REQ, S_REQ2: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_gnt) begin
          state_d = (state_q == S_REQ) ? S_WAIT : S_WAIT2;
          cnt_d   = '0;
        end
      end
      S_WAIT, S_WAIT2: begin
        stall = 1'b1;
        if (mem_rvalid) begin
          if (state_q == S_WAIT && split_q) begin
            lo_rdata_d  = mem_rdata;
            mem_addr_d  = mem_addr_q + 32'd4;
            mem_mask_d  = hi_mask_q;
            mem_wdata_d = hi_wdata_q;
            state_d     = S_REQ2;
          end else begin
            rsp_rdata_d = we_q ? '0 : load_ext;
            state_d     = S_DONE;
          end
        end else if (cnt_q == CNT_LAST) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      split_q     <= 1'b0;
      funct3_q    <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_mask_q  <= '0;
      hi_mask_q   <= '0;
      hi_wdata_q  <= '0;
      lo_rdata_q  <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      split_q     <= split_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_mask_q  <= mem_mask_d;
      hi_mask_q   <= hi_mask_d;
      hi_wdata_q  <= hi_wdata_d;
      lo_rdata_q  <= lo_rdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_mask  = mem_mask_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
